// File: rtl/collide_scan_pkg.sv
// Shared object layout, type codes and FSM state type for the collision scanner.
// The renderer uses the same field positions, so treat this layout as fixed.
package collide_scan_pkg;

  localparam int COORD_W  = 8;
  localparam int TYPE_W   = 4;
  localparam int DATALEN  = 4 * COORD_W + TYPE_W;

  localparam int X_LSB    = 0;
  localparam int Y_LSB    = X_LSB + COORD_W;
  localparam int W_LSB    = Y_LSB + COORD_W;
  localparam int H_LSB    = W_LSB + COORD_W;
  localparam int TYPE_LSB = H_LSB + COORD_W;

  localparam logic [TYPE_W-1:0] TYPE_NONE   = 4'd0;
  localparam logic [TYPE_W-1:0] TYPE_PLAYER = 4'd1;
  localparam logic [TYPE_W-1:0] TYPE_ENEMY  = 4'd2;
  localparam logic [TYPE_W-1:0] TYPE_BONUS  = 4'd3;

  typedef struct packed {
    logic [TYPE_W-1:0]  kind;
    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } obj_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_t;

  function automatic obj_t slot_of(input logic [DATALEN-1:0] raw);
    obj_t o;
    o.x    = raw[X_LSB    +: COORD_W];
    o.y    = raw[Y_LSB    +: COORD_W];
    o.w    = raw[W_LSB    +: COORD_W];
    o.h    = raw[H_LSB    +: COORD_W];
    o.kind = raw[TYPE_LSB +: TYPE_W];
    return o;
  endfunction

endpackage

// File: rtl/collide_scan_box.sv
// Combinational axis-aligned overlap test of two boxes; touching edges overlap.
// End coordinates carry one extra bit so pos+len never wraps.
module collide_box #(
  parameter int W = 9
) (
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic [W-1:0] aw,
  input  logic [W-1:0] ah,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  input  logic [W-1:0] bw,
  input  logic [W-1:0] bh,
  output logic         hit
);

  logic [W:0] a_xe, a_ye, b_xe, b_ye;
  logic       x_ovl, y_ovl;

  assign a_xe = {1'b0, ax} + {1'b0, aw};
  assign a_ye = {1'b0, ay} + {1'b0, ah};
  assign b_xe = {1'b0, bx} + {1'b0, bw};
  assign b_ye = {1'b0, by} + {1'b0, bh};

  assign x_ovl = !((a_xe < {1'b0, bx}) || (b_xe < {1'b0, ax}));
  assign y_ovl = !((a_ye < {1'b0, by}) || (b_ye < {1'b0, ay}));
  assign hit   = x_ovl && y_ovl;

endmodule

// File: rtl/collide_scan.sv
// Sequential collision engine: snapshots the object list on start and checks
// one object per cycle against the player, publishing results in DONE.
//
//   state  | meaning
//   S_IDLE | waiting for start
//   S_SCAN | testing slot idx (1..NOBJ-1) against the player
//   S_DONE | results published, done pulsed; start here rescans at once
module collide_scan
  import collide_scan_pkg::*;
#(
  parameter int                       NOBJ      = 8,
  parameter int                       MARGIN    = 2,
  parameter logic [(1<<TYPE_W)-1:0]   TYPE_MASK = {{((1<<TYPE_W)-1){1'b0}}, 1'b1} << TYPE_ENEMY
) (
  input  logic                        clk3,
  input  logic                        reset,
  input  logic                        start,
  input  logic [DATALEN*NOBJ-1:0]     gamedata,
  output logic                        busy,
  output logic                        done,
  output logic                        collide,
  output logic [$clog2(NOBJ)-1:0]     hit_index,
  output logic [$clog2(NOBJ):0]       hit_count
);

  localparam int              IW       = $clog2(NOBJ);
  localparam int              BW       = COORD_W + 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NOBJ - 1);

  scan_state_t                state, state_nxt;
  logic                       snap_load, scan_step, scan_last;

  logic [DATALEN*NOBJ-1:0]    snap;
  logic [IW-1:0]              idx;
  logic                       acc_hit;
  logic [IW-1:0]              acc_index;
  logic [IW:0]                acc_count;

  logic [COORD_W-1:0]         p_x, p_y, p_w, p_h;
  logic signed [COORD_W+1:0]  pw_eff, ph_eff;
  logic                       degenerate;
  logic [BW-1:0]              px, py, pw, ph;
  obj_t                       cand;
  logic                       box_hit, slot_hit;

  assign p_x = snap[X_LSB +: COORD_W];
  assign p_y = snap[Y_LSB +: COORD_W];
  assign p_w = snap[W_LSB +: COORD_W];
  assign p_h = snap[H_LSB +: COORD_W];

  // Shrunk player size may go negative; a non-positive size means nothing can hit.
  assign pw_eff     = $signed({2'b00, p_w}) - $signed((COORD_W+2)'(2 * MARGIN));
  assign ph_eff     = $signed({2'b00, p_h}) - $signed((COORD_W+2)'(2 * MARGIN));
  assign degenerate = pw_eff[COORD_W+1] || (pw_eff == '0) ||
                      ph_eff[COORD_W+1] || (ph_eff == '0);

  assign px = {1'b0, p_x} + BW'(MARGIN);
  assign py = {1'b0, p_y} + BW'(MARGIN);
  assign pw = pw_eff[BW-1:0];
  assign ph = ph_eff[BW-1:0];

  assign cand = slot_of(snap[int'(idx) * DATALEN +: DATALEN]);

  collide_box #(.W(BW)) u_box (
    .ax  (px),
    .ay  (py),
    .aw  (pw),
    .ah  (ph),
    .bx  ({1'b0, cand.x}),
    .by  ({1'b0, cand.y}),
    .bw  ({1'b0, cand.w}),
    .bh  ({1'b0, cand.h}),
    .hit (box_hit)
  );

  assign slot_hit = box_hit && TYPE_MASK[cand.kind] &&
                    (cand.w != '0) && (cand.h != '0) && !degenerate;

  assign scan_last = (idx == LAST_IDX);

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    snap_load = 1'b0;
    scan_step = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          snap_load = 1'b1;
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        scan_step = 1'b1;
        if (scan_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          snap_load = 1'b1;
          state_nxt = S_SCAN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      snap      <= '0;
      idx       <= '0;
      acc_hit   <= 1'b0;
      acc_index <= '0;
      acc_count <= '0;
      collide   <= 1'b0;
      hit_index <= '0;
      hit_count <= '0;
    end else if (snap_load) begin
      snap      <= gamedata;
      idx       <= IW'(1);
      acc_hit   <= 1'b0;
      acc_index <= '0;
      acc_count <= '0;
    end else if (scan_step) begin
      idx       <= idx + IW'(1);
      acc_count <= acc_count + {{IW{1'b0}}, slot_hit};
      if (slot_hit) begin
        acc_hit <= 1'b1;
        if (!acc_hit) acc_index <= idx;
      end
      // Fold the final slot in directly so results are valid in the DONE cycle.
      if (scan_last) begin
        collide   <= acc_hit || slot_hit;
        hit_index <= acc_hit ? acc_index : (slot_hit ? idx : '0);
        hit_count <= acc_count + {{IW{1'b0}}, slot_hit};
      end
    end
  end

endmodule

// File: tb/tb_collide_scan.sv
// Bench for collide_scan: two instances (MARGIN 0 and 2) share stimulus and are
// checked every cycle against a timing/result model plus literal expectations.
module tb_collide_scan;
  import collide_scan_pkg::*;

  localparam int NOBJ = 8;
  localparam int IW   = 3;
  localparam int GDW  = DATALEN * NOBJ;

  logic           clk3 = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [GDW-1:0] gamedata = '0;

  logic busy0, done0, col0, busy2, done2, col2;
  logic [IW-1:0] idx0, idx2;
  logic [IW:0]   cnt0, cnt2;

  collide_scan #(.NOBJ(NOBJ), .MARGIN(0)) dut0 (
    .clk3(clk3), .reset(reset), .start(start), .gamedata(gamedata),
    .busy(busy0), .done(done0), .collide(col0), .hit_index(idx0), .hit_count(cnt0));

  collide_scan #(.NOBJ(NOBJ), .MARGIN(2)) dut2 (
    .clk3(clk3), .reset(reset), .start(start), .gamedata(gamedata),
    .busy(busy2), .done(done2), .collide(col2), .hit_index(idx2), .hit_count(cnt2));

  always #5 clk3 = ~clk3;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit c;
    int idx;
    int cnt;
  } res_t;

  function automatic logic [DATALEN-1:0] obj(input int t, input int x, input int y,
                                             input int w, input int h);
    logic [DATALEN-1:0] o;
    o = '0;
    o[X_LSB    +: COORD_W] = COORD_W'(x);
    o[Y_LSB    +: COORD_W] = COORD_W'(y);
    o[W_LSB    +: COORD_W] = COORD_W'(w);
    o[H_LSB    +: COORD_W] = COORD_W'(h);
    o[TYPE_LSB +: TYPE_W]  = TYPE_W'(t);
    return o;
  endfunction

  // Straight from the rules: shrink player, skip non-enemies and empty boxes,
  // reject if separated on either axis.
  function automatic res_t model_scan(input logic [GDW-1:0] gd, input int m);
    res_t r;
    logic [DATALEN-1:0] o;
    int ex, ey, ew, eh, x, y, w, h, t;
    r.c = 1'b0; r.idx = 0; r.cnt = 0;
    o  = gd[0 +: DATALEN];
    ex = int'(o[X_LSB +: COORD_W]) + m;
    ey = int'(o[Y_LSB +: COORD_W]) + m;
    ew = int'(o[W_LSB +: COORD_W]) - 2 * m;
    eh = int'(o[H_LSB +: COORD_W]) - 2 * m;
    if (ew <= 0 || eh <= 0) return r;
    for (int i = 1; i < NOBJ; i++) begin
      o = gd[i*DATALEN +: DATALEN];
      x = int'(o[X_LSB +: COORD_W]);
      y = int'(o[Y_LSB +: COORD_W]);
      w = int'(o[W_LSB +: COORD_W]);
      h = int'(o[H_LSB +: COORD_W]);
      t = int'(o[TYPE_LSB +: TYPE_W]);
      if (t != int'(TYPE_ENEMY)) continue;
      if (w == 0 || h == 0) continue;
      if (ex + ew < x || x + w < ex || ey + eh < y || y + h < ey) continue;
      if (!r.c) r.idx = i;
      r.c = 1'b1;
      r.cnt++;
    end
    return r;
  endfunction

  res_t res0, res2, pend0, pend2;
  bit   have = 1'b0;
  int   cyc = 0, acc_at = 0, done_at = 0;

  // Timing model: an accepted start at edge n gives busy for n..n+NOBJ-1 and done at n+NOBJ-1.
  initial forever begin
    @(posedge clk3 or negedge reset);
    if (!reset) begin
      have = 1'b0;
      cyc  = 0;
      res0 = '{1'b0, 0, 0};
      res2 = '{1'b0, 0, 0};
    end else begin
      cyc++;
      if (start && !(have && (cyc - 1) >= acc_at && (cyc - 1) < done_at)) begin
        acc_at  = cyc;
        done_at = cyc + NOBJ - 1;
        pend0   = model_scan(gamedata, 0);
        pend2   = model_scan(gamedata, 2);
        have    = 1'b1;
      end
      if (have && cyc == done_at) begin
        res0 = pend0;
        res2 = pend2;
      end
    end
  end

  initial forever begin
    bit eb, ed;
    @(negedge clk3);
    eb = have && cyc >= acc_at && cyc <= done_at;
    ed = have && cyc == done_at;
    chk("busy0", 32'(busy0), 32'(eb));
    chk("done0", 32'(done0), 32'(ed));
    chk("collide0", 32'(col0), 32'(res0.c));
    chk("index0", 32'(idx0), 32'(res0.idx));
    chk("count0", 32'(cnt0), 32'(res0.cnt));
    chk("busy2", 32'(busy2), 32'(eb));
    chk("done2", 32'(done2), 32'(ed));
    chk("collide2", 32'(col2), 32'(res2.c));
    chk("index2", 32'(idx2), 32'(res2.idx));
    chk("count2", 32'(cnt2), 32'(res2.cnt));
  end

  task automatic set_slot(input int i, input logic [DATALEN-1:0] o);
    gamedata[i*DATALEN +: DATALEN] = o;
  endtask

  // Player (10,0,8,10); enemy in slot 3 at (18,5,4,4); other slots overlap but have w=0.
  task automatic scene1();
    set_slot(0, obj(TYPE_PLAYER, 10, 0, 8, 10));
    for (int i = 1; i < NOBJ; i++) set_slot(i, obj(TYPE_ENEMY, 12, 2, 0, 4));
    set_slot(3, obj(TYPE_ENEMY, 18, 5, 4, 4));
  endtask

  task automatic run_scan(output int k);
    k = 0;
    start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk3);
      if (n == 1) start = 1'b0;
      if (done0) begin
        k = n;
        break;
      end
    end
    if (k == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_res(input string tag, input logic c0, input int i0, input int n0,
                         input logic c2, input int i2, input int n2);
    chk({tag, "_collide0"}, 32'(col0), 32'(c0));
    chk({tag, "_index0"},   32'(idx0), 32'(i0));
    chk({tag, "_count0"},   32'(cnt0), 32'(n0));
    chk({tag, "_collide2"}, 32'(col2), 32'(c2));
    chk({tag, "_index2"},   32'(idx2), 32'(i2));
    chk({tag, "_count2"},   32'(cnt2), 32'(n2));
  endtask

  initial begin
    int k, ndone, d1, d2, gap;
    scene1();
    repeat (3) @(negedge clk3);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk_res("rst", 1'b0, 0, 0, 1'b0, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk3);

    // Touching right edge hits with no margin; margin 2 pulls the edge to 16.
    run_scan(k);
    chk("t1_latency", 32'(k), 8);
    chk_res("t1", 1'b1, 3, 1, 1'b0, 0, 0);
    repeat (3) @(negedge clk3);

    // Bonus in slot 1 is not collidable, slot 4 has h=0, slot 6 touches only without margin.
    set_slot(0, obj(TYPE_PLAYER, 20, 20, 20, 20));
    set_slot(1, obj(TYPE_BONUS, 25, 25, 5, 5));
    set_slot(2, obj(TYPE_ENEMY, 25, 25, 5, 5));
    set_slot(3, obj(TYPE_ENEMY, 100, 100, 5, 5));
    set_slot(4, obj(TYPE_ENEMY, 25, 25, 5, 0));
    set_slot(5, obj(TYPE_ENEMY, 30, 22, 3, 3));
    set_slot(6, obj(TYPE_ENEMY, 40, 25, 5, 5));
    set_slot(7, obj(TYPE_ENEMY, 35, 35, 10, 10));
    run_scan(k);
    chk_res("t2", 1'b1, 2, 4, 1'b1, 2, 3);
    repeat (2) @(negedge clk3);

    // Input changes mid-scan are ignored; the next scan sees them.
    scene1();
    start = 1'b1;
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk3);
      if (n == 1) start = 1'b0;
      if (n == 2) set_slot(3, obj(TYPE_ENEMY, 100, 100, 4, 4));
      if (done0) begin
        k = n;
        break;
      end
    end
    chk("t3_latency", 32'(k), 8);
    chk_res("t3a", 1'b1, 3, 1, 1'b0, 0, 0);
    repeat (2) @(negedge clk3);
    run_scan(k);
    chk_res("t3b", 1'b0, 0, 0, 1'b0, 0, 0);
    repeat (2) @(negedge clk3);

    // Start during SCAN is dropped; start in DONE chains a second scan.
    scene1();
    start = 1'b1;
    ndone = 0; d1 = 0; d2 = 0; gap = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk3);
      start = (n == 3);
      if (ndone < 2 && !busy0) gap++;
      if (done0) begin
        ndone++;
        if (ndone == 1) begin d1 = n; start = 1'b1; end
        else d2 = n;
      end
    end
    chk("t4_ndone", 32'(ndone), 2);
    chk("t4_first", 32'(d1), 8);
    chk("t4_spacing", 32'(d2 - d1), 8);
    chk("t4_busy_gap", 32'(gap), 0);
    chk_res("t4", 1'b1, 3, 1, 1'b0, 0, 0);

    // Asynchronous reset mid-scan aborts and clears published results.
    start = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk3);
      start = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    chk("t5_busy0", 32'(busy0), 0);
    chk("t5_busy2", 32'(busy2), 0);
    chk_res("t5", 1'b0, 0, 0, 1'b0, 0, 0);
    repeat (2) @(negedge clk3);
    reset = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk3);
      if (done0 || done2) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 0);

    // Player w=4: degenerate with margin 2, still a full-length scan.
    set_slot(0, obj(TYPE_PLAYER, 10, 0, 4, 10));
    for (int i = 1; i < NOBJ; i++) set_slot(i, obj(TYPE_ENEMY, 200, 200, 4, 4));
    set_slot(3, obj(TYPE_ENEMY, 12, 2, 2, 2));
    run_scan(k);
    chk("t6_latency", 32'(k), 8);
    chk("t6_done2", 32'(done2), 1);
    chk_res("t6", 1'b1, 3, 1, 1'b0, 0, 0);
    repeat (3) @(negedge clk3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/collide_scan.md
# collide_scan

Parametrised, sequential collision engine for the dinosaur game. On a `start` pulse it snapshots the packed object list, scans objects 1..NOBJ-1 against the player (object 0) one per cycle, and reports any collision, the first colliding index, and the hit count. It replaces the single-cycle all-objects comparator and sits between the game-state register and the game-over/score logic.

## Interface
- NOBJ, 8: objects in `gamedata`, including the player at slot 0; ≥2.
- MARGIN, 2: hitbox forgiveness in pixels, applied on every side of the player box.
- TYPE_MASK, 1 << `enemytype: bit t set means object type t is collidable.
- clk3  in  1  game clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  scan request; one-cycle pulse.
- gamedata  in  `datalen*NOBJ  packed objects; slot i at [i*`datalen +: `datalen]; field layout from the shared defines.
- busy  out  1  high from the cycle after `start` is accepted through the `done` cycle.
- done  out  1  one-cycle pulse when results update.
- collide  out  1  at least one hit in the last scan.
- hit_index  out  $clog2(NOBJ)  lowest colliding slot; 0 if none.
- hit_count  out  $clog2(NOBJ)+1  number of colliding slots.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE + `start`: latch all of `gamedata` into a snapshot register; set idx=1; clear the accumulators; go to SCAN. `gamedata` changes after this are ignored.
- SCAN: evaluate slot idx against the player. A slot hits only if all of these hold:
  - TYPE_MASK[type] is set;
  - width ≠ 0 and height ≠ 0;
  - it overlaps the player box on both axes.
- The first hit records hit_index=idx. hit_count increments on every hit. idx increments each cycle; after idx=NOBJ-1, go to DONE.
- DONE: copy the accumulators to `collide`/`hit_index`/`hit_count`; pulse `done`.
  - `start` in DONE is accepted: re-snapshot and go to SCAN. `busy` stays high.
  - Otherwise return to IDLE.
- `start` while in SCAN is ignored; no queueing.
- Player effective box: x+MARGIN, y+MARGIN, w-2*MARGIN, h-2*MARGIN.
  - If w ≤ 2*MARGIN or h ≤ 2*MARGIN, the player is degenerate: no hits, scan still runs the full length.
- Axis overlap is "not (a.pos+a.len < b.pos or b.pos+b.len < a.pos)". Touching edges count as a hit.
- Arithmetic: all sums are computed one bit wider than the coordinate field, so there is no wrap-around. The margin subtraction uses a signed compare against zero before use.
- Result outputs change only in the DONE cycle and hold until the next DONE.

## Timing
- Reset values: state IDLE, busy=0, done=0, collide=0, hit_index=0, hit_count=0, snapshot=0.
- Reset is asynchronous and may occur mid-scan: the scan is aborted, no `done` is produced, and outputs return to their reset values.
- Latency: `start` sampled at edge T → SCAN cycles T+1..T+NOBJ-1 → `done`=1 and results valid in cycle T+NOBJ.
- Back-to-back: with `start` high in the DONE cycle, the next `done` follows NOBJ cycles later.
- `busy` rises in cycle T+1 and falls after the last DONE cycle.

## Structure
- Shared defines/package: `datalen`; field start/len for x, y, width, height and type; `enemytype` and any other type codes. These are used unchanged by the renderer.
- Sub-module `collide_box`: combinational overlap of two boxes.
  - Inputs: x, y, w, h of each box.
  - Output: hit.
  - Instantiated once and time-multiplexed by idx.
- Top level holds the FSM, the snapshot, the idx counter and the accumulators.

## Test plan
- MARGIN=0; player (x10,y0,w8,h10); enemy slot 3 at (x18,y5,w4,h4); other slots w=0; pulse `start` → `done` at T+8 with collide=1, hit_index=3, hit_count=1.
- Same stimulus with MARGIN=2 → collide=0, hit_index=0, hit_count=0 (player right edge is 16 < 18).
- Enemies overlapping in slots 2, 5 and 7, plus a non-masked type overlapping in slot 1 → hit_index=2, hit_count=3.
- Change `gamedata` to non-overlapping values at T+2 of a colliding scan → results still collide=1; the next scan reports 0.
- Pulse `start` at T+3 (ignored), then again in the DONE cycle → exactly two `done` pulses, 8 cycles apart, and `busy` continuous.
- Assert `reset` at T+4 → no `done`, all outputs 0. Player w=4 with MARGIN=2 → degenerate, collide=0.
